word_uart_tx: RTL and testbench
===============================

WORD_UART_TX -- requirements
Module: word_uart_tx

Interface
REQ-001 Parameter WORDWID, default 32: transmit word width in bits; SHALL be a multiple of 8.
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 n_btn_rst  input  1  reset, asynchronous assert, active-low.
REQ-004 i_setup  input  31  UART setup; bits [23:0] = clocks per bit (CPB), bits [30:24] ignored.
REQ-005 i_valid  input  1  word offered for transmission.
REQ-006 i_data  input  WORDWID  word to transmit.
REQ-007 o_ready  output  1  block can accept a word this cycle.
REQ-008 o_busy  output  1  frame in progress (inverse of o_ready).
REQ-009 o_uart_tx  output  1  serial line, idle high, registered.

Function
REQ-010 Handshake: word accepted on the rising edge where i_valid && o_ready; o_ready SHALL deassert the following cycle.
REQ-011 On accept, i_data and CPB SHALL be latched; later changes to i_data or i_setup SHALL NOT affect the word in flight.
REQ-012 CPB values 0 or 1 SHALL be treated as 2.
REQ-013 Framing: 8N1 per byte: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity, no inter-byte gap beyond the stop bit.
REQ-014 Byte order: most significant byte (i_data[WORDWID-1 -: 8]) first, least significant byte last.
REQ-015 Each bit SHALL be held on o_uart_tx for exactly CPB clocks.
REQ-016 Timing: accept on edge 0 -> start bit visible from cycle 1; whole word occupies exactly (WORDWID/8)*10*CPB cycles; o_ready SHALL be high in cycle (WORDWID/8)*10*CPB+1 with line high.
REQ-017 States: IDLE (line high, o_ready=1) -> START on accept -> DATA (8 bits) -> STOP -> START if bytes remain, else IDLE.
REQ-018 Back-to-back: i_valid held high -> next word accepted the first cycle o_ready=1; the line stays high exactly 1 cycle between the last stop bit and the next start bit.
REQ-019 i_valid while busy SHALL be ignored; no buffering, no drop indication.
REQ-020 Bit counter SHALL count down from CPB-1 to 0 and reload; no wrap-around glitch at byte or word boundary.

Reset
REQ-021 On n_btn_rst low, immediately: o_uart_tx=1, o_ready=1, o_busy=0, state IDLE, counters and latched data cleared.
REQ-022 Reset mid-frame SHALL abandon the partial byte/word; no resume after release.
REQ-023 First accept possible on the first rising edge after n_btn_rst deasserts.

Structure
REQ-024 Shared package uart_pkg SHALL hold the tx state enum (IDLE, START, DATA, STOP), the CPB field width (24), the CPB minimum (2), and frame bit count (10).
REQ-025 Per-byte shifting and bit timing SHALL be one sub-module uart_byte_tx (byte in, start/done handshake, o_uart_tx); word_uart_tx sequences bytes and owns the word handshake.

Verification
REQ-026 CPB=4, send 0xA5C3_0F81 -> decoded bytes A5, C3, 0F, 81 in order; each bit 4 cycles; o_ready returns at cycle 161.
REQ-027 i_setup=0 (CPB clamped to 2), send 0x0000_00FF -> 80-cycle frame, last byte FF; every bit exactly 2 cycles.
REQ-028 i_valid held high, two words 0x12345678 then 0x9ABCDEF0, CPB=3 -> 8 correct bytes; exactly 1 high idle cycle between words.
REQ-029 Change i_data and i_setup every cycle while busy -> transmitted word and bit period match the values at accept.
REQ-030 Assert n_btn_rst low in the middle of byte 2 -> o_uart_tx high, o_ready high same cycle; after release, new word 0x11223344 sent cleanly.
REQ-031 Loopback: o_uart_tx into the existing receive aggregator with the same i_setup -> its valid pulse returns the transmitted 32-bit word.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: byte-level FSM states, CPB field sizing
// and the CPB clamp used when a word is accepted.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int              CPB_W      = 24;
  localparam logic [CPB_W-1:0] CPB_MIN   = 24'd2;
  localparam int              FRAME_BITS = 10;

  // Bit periods shorter than two clocks cannot be timed by the countdown.
  function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] cpb);
    return (cpb < CPB_MIN) ? CPB_MIN : cpb;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one byte as an 8N1 frame; done_o flags the last clock of the
// stop bit so the next byte can start with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
(
  input  logic             i_clk,
  input  logic             n_btn_rst,
  input  logic             start_i,
  input  logic [7:0]       byte_i,
  input  logic [CPB_W-1:0] cpb_i,
  output logic             done_o,
  output logic             tx_o
);

  tx_state_e        state_q;
  logic [CPB_W-1:0] cnt_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_q;
  logic             tx_q;

  // Byte framing FSM: each bit is held for cpb_i clocks via a countdown to zero.
  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= START;
            tx_q    <= 1'b0;
            shift_q <= byte_i;
            cnt_q   <= cpb_i - 24'd1;
          end
        end
        START: begin
          if (cnt_q != 24'd0) begin
            cnt_q <= cnt_q - 24'd1;
          end else begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= 3'd0;
            cnt_q   <= cpb_i - 24'd1;
          end
        end
        DATA: begin
          if (cnt_q != 24'd0) begin
            cnt_q <= cnt_q - 24'd1;
          end else if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            cnt_q   <= cpb_i - 24'd1;
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            cnt_q   <= cpb_i - 24'd1;
          end
        end
        STOP: begin
          if (cnt_q != 24'd0) begin
            cnt_q <= cnt_q - 24'd1;
          end else if (start_i) begin
            state_q <= START;
            tx_q    <= 1'b0;
            shift_q <= byte_i;
            cnt_q   <= cpb_i - 24'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign done_o = (state_q == STOP) && (cnt_q == 24'd0);
  assign tx_o   = tx_q;

endmodule

// File: rtl/word_uart_tx.sv
// Word-wide UART transmitter: accepts a WORDWID-bit word and sends it as
// consecutive 8N1 bytes, most significant byte first.
module word_uart_tx
  import uart_pkg::*;
#(
  parameter int WORDWID = 32
) (
  input  logic               i_clk,
  input  logic               n_btn_rst,
  input  logic [30:0]        i_setup,
  input  logic               i_valid,
  input  logic [WORDWID-1:0] i_data,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_uart_tx
);

  localparam int NB = WORDWID / 8;

  logic               ready_q;
  logic               busy_q;
  logic [7:0]         rem_q;
  logic [WORDWID-1:0] word_q;
  logic [CPB_W-1:0]   cpb_q;

  logic               accept_s;
  logic               done_s;
  logic               start_s;
  logic [7:0]         byte_s;
  logic [CPB_W-1:0]   cpb_s;
  logic               unused_setup_s;

  assign unused_setup_s = ^i_setup[30:24];

  // Next byte selection: the first byte comes straight from i_data so the
  // start bit appears the cycle after accept.
  always_comb begin
    accept_s = i_valid && ready_q;
    cpb_s    = accept_s ? clamp_cpb(i_setup[CPB_W-1:0]) : cpb_q;
    if (accept_s) begin
      start_s = 1'b1;
      byte_s  = i_data[WORDWID-1 -: 8];
    end else if (done_s && (rem_q != 8'd0)) begin
      start_s = 1'b1;
      byte_s  = word_q[WORDWID-1 -: 8];
    end else begin
      start_s = 1'b0;
      byte_s  = word_q[WORDWID-1 -: 8];
    end
  end

  // Word handshake and byte sequencing; word_q keeps the next byte on top.
  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rem_q   <= 8'd0;
      word_q  <= '0;
      cpb_q   <= '0;
    end else if (accept_s) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      word_q  <= i_data << 4'd8;
      rem_q   <= 8'(NB - 1);
      cpb_q   <= cpb_s;
    end else if (done_s && (rem_q != 8'd0)) begin
      word_q  <= word_q << 4'd8;
      rem_q   <= rem_q - 8'd1;
    end else if (done_s) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end
  end

  uart_byte_tx u_byte_tx (
    .i_clk     (i_clk),
    .n_btn_rst (n_btn_rst),
    .start_i   (start_s),
    .byte_i    (byte_s),
    .cpb_i     (cpb_s),
    .done_o    (done_s),
    .tx_o      (o_uart_tx)
  );

  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Self-checking bench for word_uart_tx: waveform model from framing rules plus
// an independent mid-bit receiver that reassembles the word.
module tb_word_uart_tx;

  logic        i_clk = 1'b0;
  logic        n_btn_rst = 1'b0;
  logic [30:0] i_setup = 31'd0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        o_ready;
  logic        o_busy;
  logic        o_uart_tx;

  int vectors = 0;
  int miscompares = 0;

  word_uart_tx #(.WORDWID(32)) dut (
    .i_clk     (i_clk),
    .n_btn_rst (n_btn_rst),
    .i_setup   (i_setup),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_uart_tx (o_uart_tx)
  );

  always #5 i_clk = ~i_clk;

  function automatic int eff_cpb(input logic [30:0] setup);
    int c;
    c = int'(setup[23:0]);
    return (c < 2) ? 2 : c;
  endfunction

  // Expected line level in cycle c (1-based) after accept.
  function automatic logic exp_line(input logic [31:0] w, input int cpb, input int c);
    int j, b, pos;
    j = (c - 1) / cpb;
    b = j / 10;
    pos = j % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[24 - 8 * b + (pos - 1)];
  endfunction

  // Present a word at the current (negedge) time and let the next edge accept it.
  task automatic start_word(input logic [31:0] w, input logic [30:0] setup);
    i_valid = 1'b1;
    i_data  = w;
    i_setup = setup;
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept: o_ready=%b expected 1", o_ready);
    end
    @(posedge i_clk);
  endtask

  // Check every cycle of the frame after accept, then the trailing idle cycle.
  task automatic run_frame(input logic [31:0] w, input int cpb, input bit scramble,
                           input bit hold_valid, input logic [31:0] next_word);
    int total;
    logic samp [0:39];
    logic [31:0] dec;
    total = 40 * cpb;
    for (int i = 0; i < 40; i++) samp[i] = 1'bx;
    for (int c = 1; c <= total; c++) begin
      @(negedge i_clk);
      if (scramble) begin
        i_data  = $urandom;
        i_setup = 31'($urandom);
        i_valid = 1'($urandom_range(0, 1));
      end else if (hold_valid) begin
        i_data  = next_word;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      if ((c - 1) % cpb == cpb / 2) samp[(c - 1) / cpb] = o_uart_tx;
      vectors++;
      if (o_uart_tx !== exp_line(w, cpb, c) || o_ready !== 1'b0 || o_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL frame_cycle word=%h cyc=%0d: tx=%b ready=%b busy=%b expected tx=%b ready=0 busy=1",
                 w, c, o_uart_tx, o_ready, o_busy, exp_line(w, cpb, c));
      end
    end
    @(negedge i_clk);
    if (!hold_valid) i_valid = 1'b0;
    vectors++;
    if (o_uart_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL end_of_frame cyc=%0d: tx=%b ready=%b busy=%b expected 1 1 0",
               total + 1, o_uart_tx, o_ready, o_busy);
    end
    dec = 32'd0;
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (samp[b * 10] !== 1'b0 || samp[b * 10 + 9] !== 1'b1) begin
        miscompares++;
        $display("FAIL framing byte=%0d: start=%b stop=%b expected 0 1", b, samp[b * 10], samp[b * 10 + 9]);
      end
      for (int i = 0; i < 8; i++) dec[24 - 8 * b + i] = samp[b * 10 + 1 + i];
    end
    vectors++;
    if (dec !== w) begin
      miscompares++;
      $display("FAIL loopback_word: received %h expected %h", dec, w);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    vectors++;
    if (o_uart_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b expected 1 1 0", o_uart_tx, o_ready, o_busy);
    end
    n_btn_rst = 1'b1;
  endtask

  task automatic test_cpb4();
    start_word(32'hA5C3_0F81, 31'd4);
    run_frame(32'hA5C3_0F81, 4, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_cpb_clamp();
    start_word(32'h0000_00FF, 31'd0);
    run_frame(32'h0000_00FF, 2, 1'b0, 1'b0, 32'd0);
    start_word(32'h8000_0001, 31'd1);
    run_frame(32'h8000_0001, 2, 1'b0, 1'b0, 32'd0);
    start_word(32'h3C00_55AA, {7'h7F, 24'd3});
    run_frame(32'h3C00_55AA, 3, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_back_to_back();
    start_word(32'h1234_5678, 31'd3);
    run_frame(32'h1234_5678, 3, 1'b0, 1'b1, 32'h9ABC_DEF0);
    @(posedge i_clk);
    run_frame(32'h9ABC_DEF0, 3, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_input_changes();
    start_word(32'hC0FF_EE42, 31'd3);
    run_frame(32'hC0FF_EE42, 3, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_reset_midframe();
    start_word(32'hDEAD_BEEF, 31'd4);
    for (int c = 1; c <= 55; c++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
    end
    n_btn_rst = 1'b0;
    #1;
    vectors++;
    if (o_uart_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midframe: tx=%b ready=%b busy=%b expected 1 1 0", o_uart_tx, o_ready, o_busy);
    end
    repeat (2) @(negedge i_clk);
    vectors++;
    if (o_uart_tx !== 1'b1 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: tx=%b ready=%b expected 1 1", o_uart_tx, o_ready);
    end
    n_btn_rst = 1'b1;
    start_word(32'h1122_3344, 31'd4);
    run_frame(32'h1122_3344, 4, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [30:0] setup;
    for (int n = 0; n < 5; n++) begin
      w = $urandom;
      setup = (31'($urandom) & 31'h7F00_0000) | 31'($urandom_range(0, 5));
      start_word(w, setup);
      run_frame(w, eff_cpb(setup), 1'b1, 1'b0, 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_cpb4();
    test_cpb_clamp();
    test_back_to_back();
    test_input_changes();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
